// File: rtl/pico_sample_scheduler.sv
// Qualifies the 9-bit Pico sensor word and commits it to the display
// registers only once it has held steady, and only at the start of
// vertical blanking. Also flags a stale link when no steady reading
// has been seen for a long time.
module pico_sample_scheduler #(
  parameter int STABLE_CYCLES = 1000,
  parameter int STALE_CYCLES  = 50_000_000
) (
  input  logic       MAX10_CLK1_50,
  input  logic       reset_n,
  input  logic [8:0] sample,
  input  logic       vblank,
  output logic [5:0] hum_out,
  output logic [2:0] moist_out,
  output logic       valid,
  output logic       update,
  output logic       stale,
  output logic [7:0] commit_count
);

  localparam int STAB_W  = $clog2(STABLE_CYCLES);
  localparam int STALE_W = $clog2(STALE_CYCLES + 1);
  localparam logic [STAB_W-1:0]  STAB_MAX  = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(STALE_CYCLES);

  typedef enum logic {
    TRACK   = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [8:0]          prev_q;
  logic [STAB_W-1:0]   stab_q, stab_d;
  logic [2:0]          vb_q;
  logic [8:0]          cand_q, cand_d;
  logic [5:0]          hum_q, hum_d;
  logic [2:0]          moist_q, moist_d;
  logic                valid_q, valid_d;
  logic                update_q, update_d;
  logic [7:0]          cc_q, cc_d;
  logic [STALE_W-1:0]  stale_cnt_q, stale_cnt_d;
  logic                stale_q, stale_d;

  logic change;
  logic qualify;
  logic vb_rise;

  // Stability tracking: restart on any bus change, otherwise count up to the limit.
  always_comb begin
    change  = (sample != prev_q);
    qualify = !change && (stab_q == STAB_MAX);
    if (change) begin
      stab_d = '0;
    end else if (stab_q == STAB_MAX) begin
      stab_d = stab_q;
    end else begin
      stab_d = stab_q + 1'b1;
    end
  end

  // vblank arrives from the 25 MHz domain: two sync flops plus one for edge detect.
  assign vb_rise = vb_q[1] & ~vb_q[2];

  // Commit scheduler: capture a qualified new value, then load it on the next vblank start.
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    hum_d    = hum_q;
    moist_d  = moist_q;
    valid_d  = valid_q;
    update_d = 1'b0;
    cc_d     = cc_q;
    case (state_q)
      TRACK: begin
        if (qualify && (!valid_q || (sample != {moist_q, hum_q}))) begin
          cand_d  = sample;
          state_d = PENDING;
        end
      end
      PENDING: begin
        // A change on the bus beats a simultaneous vblank start: the value was not steady.
        if (change) begin
          cand_d  = '0;
          state_d = TRACK;
        end else if (vb_rise) begin
          moist_d  = cand_q[8:6];
          hum_d    = cand_q[5:0];
          valid_d  = 1'b1;
          update_d = 1'b1;
          cc_d     = cc_q + 8'd1;
          state_d  = TRACK;
        end
      end
      default: state_d = TRACK;
    endcase
  end

  // Stale timer: cleared by any qualification, saturates at the limit.
  always_comb begin
    if (qualify) begin
      stale_cnt_d = '0;
    end else if (stale_cnt_q == STALE_MAX) begin
      stale_cnt_d = stale_cnt_q;
    end else begin
      stale_cnt_d = stale_cnt_q + 1'b1;
    end
    stale_d = (stale_cnt_d == STALE_MAX);
  end

  // Input history, stability counter and vblank synchroniser.
  always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= '0;
      stab_q <= '0;
      vb_q   <= '0;
    end else begin
      prev_q <= sample;
      stab_q <= stab_d;
      vb_q   <= {vb_q[1:0], vblank};
    end
  end

  // Scheduler state, candidate and committed display value.
  always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= TRACK;
      cand_q   <= '0;
      hum_q    <= '0;
      moist_q  <= '0;
      valid_q  <= 1'b0;
      update_q <= 1'b0;
      cc_q     <= '0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      hum_q    <= hum_d;
      moist_q  <= moist_d;
      valid_q  <= valid_d;
      update_q <= update_d;
      cc_q     <= cc_d;
    end
  end

  // Stale timer and its registered flag.
  always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      stale_cnt_q <= '0;
      stale_q     <= 1'b0;
    end else begin
      stale_cnt_q <= stale_cnt_d;
      stale_q     <= stale_d;
    end
  end

  assign hum_out      = hum_q;
  assign moist_out    = moist_q;
  assign valid        = valid_q;
  assign update       = update_q;
  assign stale        = stale_q;
  assign commit_count = cc_q;

endmodule

// File: tb/tb_pico_sample_scheduler.sv
// Bench for pico_sample_scheduler with STABLE_CYCLES=8, STALE_CYCLES=100.
module tb_pico_sample_scheduler;

  localparam int STABLE = 8;
  localparam int STALE  = 100;

  logic       clk;
  logic       reset_n;
  logic [8:0] sample;
  logic       vblank;
  logic [5:0] hum_out;
  logic [2:0] moist_out;
  logic       valid;
  logic       update;
  logic       stale;
  logic [7:0] commit_count;

  int tests = 0;
  int fails = 0;
  int n_upd = 0;

  pico_sample_scheduler #(
    .STABLE_CYCLES(STABLE),
    .STALE_CYCLES (STALE)
  ) dut (
    .MAX10_CLK1_50(clk),
    .reset_n      (reset_n),
    .sample       (sample),
    .vblank       (vblank),
    .hum_out      (hum_out),
    .moist_out    (moist_out),
    .valid        (valid),
    .update       (update),
    .stale        (stale),
    .commit_count (commit_count)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference model: run length of the current bus value, recent vblank
  // samples, a pending candidate and the committed display value.
  logic [8:0] m_last;
  int         m_run;
  logic       m_vh [3];
  logic       m_pend;
  logic [8:0] m_cand;
  logic [5:0] m_hum;
  logic [2:0] m_moist;
  logic       m_valid;
  logic       m_update;
  int         m_scnt;
  logic       m_stale;
  int         m_cc;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last = '0; m_run = 1;
    for (int i = 0; i < 3; i++) m_vh[i] = 1'b0;
    m_pend = 1'b0; m_cand = '0;
    m_hum = '0; m_moist = '0; m_valid = 1'b0; m_update = 1'b0;
    m_scnt = 0; m_stale = 1'b0; m_cc = 0;
  endtask

  task automatic model_edge(input logic [8:0] s, input logic v);
    logic ch, q, rise;
    ch   = (s != m_last);
    m_run = ch ? 1 : m_run + 1;
    q    = (m_run >= STABLE + 1);
    rise = m_vh[1] && !m_vh[2];
    m_update = 1'b0;
    if (!m_pend) begin
      if (q && (!m_valid || s != {m_moist, m_hum})) begin
        m_pend = 1'b1;
        m_cand = s;
      end
    end else if (ch) begin
      m_pend = 1'b0;
    end else if (rise) begin
      m_hum    = m_cand[5:0];
      m_moist  = m_cand[8:6];
      m_valid  = 1'b1;
      m_update = 1'b1;
      m_cc     = (m_cc + 1) % 256;
      m_pend   = 1'b0;
    end
    if (q) m_scnt = 0;
    else if (m_scnt < STALE) m_scnt = m_scnt + 1;
    m_stale = (m_scnt == STALE);
    m_vh[2] = m_vh[1];
    m_vh[1] = m_vh[0];
    m_vh[0] = v;
    m_last  = s;
  endtask

  // One clock: drive inputs, advance model, compare all outputs after the edge.
  task automatic step(input logic [8:0] s, input logic v);
    sample = s;
    vblank = v;
    @(posedge clk);
    model_edge(s, v);
    #1;
    check("cycle_model",
          int'({hum_out, moist_out, valid, update, stale, commit_count}),
          int'({m_hum, m_moist, m_valid, m_update, m_stale, m_cc[7:0]}));
    if (update) n_upd++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sample  = '0;
    vblank  = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    check("reset_outputs",
          int'({hum_out, moist_out, valid, update, stale, commit_count}), 0);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [8:0] s;
    int         hum;
    int         moist;
    int         commits;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int base;
    int exp_cc;
    logic [8:0] pick [4];

    vecs[0] = '{9'h12D, 45, 4, 1};
    vecs[1] = '{9'h12D, 45, 4, 0};
    vecs[2] = '{9'h0AA, 42, 2, 1};
    vecs[3] = '{9'h1FF, 63, 7, 1};
    vecs[4] = '{9'h000,  0, 0, 1};
    vecs[5] = '{9'h000,  0, 0, 0};
    vecs[6] = '{9'h1C0,  0, 7, 1};
    pick[0] = 9'h000; pick[1] = 9'h12D; pick[2] = 9'h0AA; pick[3] = 9'h1FF;

    do_reset();

    // Reset then first commit of value 0.
    repeat (10) step(9'h000, 1'b0);
    step(9'h000, 1'b1);
    step(9'h000, 1'b1);
    check("first_valid_early", int'(valid), 0);
    step(9'h000, 1'b1);
    check("first_valid", int'(valid), 1);
    check("first_update", int'(update), 1);
    check("first_hum", int'(hum_out), 0);
    check("first_count", int'(commit_count), 1);
    step(9'h000, 1'b1);
    check("first_update_len", int'(update), 0);
    repeat (3) step(9'h000, 1'b0);

    // Normal update: 0x12D, vblank rises 50 clocks after PENDING.
    repeat (9) step(9'h12D, 1'b0);
    repeat (50) step(9'h12D, 1'b0);
    step(9'h12D, 1'b1);
    step(9'h12D, 1'b1);
    check("norm_hum_early", int'(hum_out), 0);
    step(9'h12D, 1'b1);
    check("norm_hum", int'(hum_out), 45);
    check("norm_moist", int'(moist_out), 4);
    check("norm_update", int'(update), 1);
    step(9'h12D, 1'b1);
    check("norm_update_len", int'(update), 0);
    repeat (3) step(9'h12D, 1'b0);

    // Glitch rejection: toggle every 5 clocks for 200 clocks.
    base = n_upd;
    for (int c = 0; c < 200; c++)
      step(((c / 5) % 2 == 0) ? 9'h055 : 9'h133, ((c % 20) < 10) ? 1'b1 : 1'b0);
    check("glitch_no_commit", n_upd - base, 0);
    check("glitch_stale", int'(stale), 1);
    repeat (8) step(9'h0AA, 1'b0);
    check("stale_before_qual", int'(stale), 1);
    step(9'h0AA, 1'b0);
    check("stale_cleared", int'(stale), 0);

    // Abort in PENDING: change on the same edge as vb_rise.
    base = n_upd;
    step(9'h0AA, 1'b1);
    step(9'h0AA, 1'b1);
    step(9'h0C3, 1'b1);
    check("abort_no_update", int'(update), 0);
    check("abort_hum_kept", int'(hum_out), 45);
    repeat (15) step(9'h0C3, 1'b1);
    check("abort_wait_frame", n_upd - base, 0);
    repeat (3) step(9'h0C3, 1'b0);
    repeat (3) step(9'h0C3, 1'b1);
    check("abort_next_frame", n_upd - base, 1);
    check("abort_new_hum", int'(hum_out), 3);
    check("abort_new_moist", int'(moist_out), 3);

    // Duplicate suppression after a short excursion.
    base = n_upd;
    repeat (3) step(9'h001, 1'b0);
    repeat (12) step(9'h0C3, 1'b0);
    repeat (4) step(9'h0C3, 1'b1);
    check("dup_suppressed", n_upd - base, 0);

    // Table-driven commits from reset.
    do_reset();
    exp_cc = 0;
    foreach (vecs[i]) begin
      base = n_upd;
      repeat (10) step(vecs[i].s, 1'b0);
      repeat (4) step(vecs[i].s, 1'b1);
      step(vecs[i].s, 1'b0);
      exp_cc += vecs[i].commits;
      check("vec_hum", int'(hum_out), vecs[i].hum);
      check("vec_moist", int'(moist_out), vecs[i].moist);
      check("vec_commits", n_upd - base, vecs[i].commits);
      check("vec_count", int'(commit_count), exp_cc);
    end

    // 256 distinct commits from reset wrap the counter to 0.
    do_reset();
    base = n_upd;
    for (int k = 0; k < 256; k++) begin
      logic [8:0] s;
      s = 9'((k * 37 + 1) % 512);
      repeat (9) step(s, 1'b0);
      repeat (3) step(s, 1'b1);
    end
    check("wrap_commits", n_upd - base, 256);
    check("wrap_count", int'(commit_count), 0);
    check("wrap_valid", int'(valid), 1);

    // Reset asserted between qualify and vblank.
    repeat (10) step(9'h1AB, 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    check("midrst_outputs",
          int'({hum_out, moist_out, valid, update, stale, commit_count}), 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    base = n_upd;
    repeat (20) step(9'h1AB, 1'b0);
    check("midrst_no_update", n_upd - base, 0);
    check("midrst_valid", int'(valid), 0);

    // Randomized traffic against the model.
    begin
      int s_left, v_left;
      logic [8:0] rs;
      logic rv;
      s_left = 0; v_left = 0; rs = '0; rv = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        if (s_left == 0) begin
          if ($urandom_range(0, 4) == 0) rs = 9'($urandom_range(0, 511));
          else rs = pick[$urandom_range(0, 3)];
          s_left = $urandom_range(1, 14);
        end
        if (v_left == 0) begin
          rv = ~rv;
          v_left = $urandom_range(2, 30);
        end
        step(rs, rv);
        s_left--;
        v_left--;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
